// File: rtl/tt_serial_add_pkg.sv
// tt_serial_add_pkg: shared states, pin indices and default width for the serial adder tile
package tt_serial_add_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int VALID_IDX = 2;
  localparam int START_IDX = 3;
  localparam int SUM_IDX = 0;
  localparam int CARRY_IDX = 1;
  localparam int DONE_IDX = 2;
  localparam int BUSY_IDX = 3;
  localparam int CNT_LSB = 4;
  localparam int OVF_IDX = 7;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/tt_um_serial_adder_ha_cell.sv
// ha_cell: combinational half adder
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/tt_um_serial_adder.sv
// tt_um_serial_adder: LSB-first bit-serial adder with parallel result register
module tt_um_serial_adder
  import tt_serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t state_q, state_d;
  logic carry_q, carry_d, sum_q, sum_d, ovf_q, ovf_d;
  logic [2:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic s1, c1, s, c2, cout, last;
  logic unused_ok;
  ha_cell u_ha0 (.a(ui_in[A_IDX]), .b(ui_in[B_IDX]), .sum(s1), .carry(c1));
  ha_cell u_ha1 (.a(s1), .b(carry_q), .sum(s), .carry(c2));
  assign cout = c1 | c2;
  assign last = count_q == 3'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    count_d = count_q;
    result_d = result_q;
    if (ena && ui_in[START_IDX]) begin
      state_d = ACCUM;
      carry_d = 1'b0;
      sum_d = 1'b0;
      ovf_d = 1'b0;
      count_d = '0;
      result_d = '0;
    end else if (ena && state_q == ACCUM && ui_in[VALID_IDX]) begin
      carry_d = cout;
      sum_d = s;
      result_d = WIDTH'({s, result_q} >> 1);
      count_d = last ? 3'd0 : count_q + 3'd1;
      state_d = last ? DONE : ACCUM;
      ovf_d = last ? cout : ovf_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      sum_q <= 1'b0;
      ovf_q <= 1'b0;
      count_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      count_q <= count_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    uo_out = '0;
    uo_out[SUM_IDX] = sum_q;
    uo_out[CARRY_IDX] = carry_q;
    uo_out[DONE_IDX] = state_q == DONE;
    uo_out[BUSY_IDX] = state_q == ACCUM;
    uo_out[CNT_LSB +: 3] = count_q;
    uo_out[OVF_IDX] = ovf_q;
  end
  assign uio_out = 8'(result_q);
  assign uio_oe = 8'hFF;
  assign unused_ok = &{1'b0, ui_in[7:4], uio_in};
endmodule

// File: tb/tb_tt_um_serial_adder.sv
// tb_tt_um_serial_adder: directed and random checks against an arithmetic reference model
module tb_tt_um_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int checks = 0;
  int failures = 0;
  tt_um_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_uo(input int a, input int b, input int k);
    int s, m, sb, cy;
    s = a + b;
    m = (1 << k) - 1;
    sb = (k == 0) ? 0 : (s >> (k - 1)) & 1;
    cy = ((a & m) + (b & m)) >> k;
    return 8'({((k == W) ? (s >> W) & 1 : 0), 3'(k % W), (k < W), (k == W), cy[0], sb[0]});
  endfunction
  function automatic logic [7:0] exp_res(input int a, input int b, input int k);
    int s, m;
    s = a + b;
    m = (1 << k) - 1;
    return 8'(((s & m) << (W - k)) & ((1 << W) - 1));
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_state(input string tag, input int a, input int b, input int k);
    chk({tag, "_uo"}, uo_out, exp_uo(a, b, k));
    chk({tag, "_result"}, uio_out, exp_res(a, b, k));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    ui_in = 8'h08;
    tick();
    ui_in = 8'h00;
    check_state("start", 0, 0, 0);
  endtask
  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int k);
    ui_in = {5'b00001, b[k], a[k]} << 0;
    ui_in = {4'b0000, 1'b0, 1'b1, b[k], a[k]};
    tick();
    ui_in = 8'h00;
    check_state("accept", a, b, k + 1);
  endtask
  task automatic gaps(input logic [7:0] a, input logic [7:0] b, input int k, input int n, input bit force_ena);
    for (int i = 0; i < n; i++) begin
      if (force_ena || $urandom_range(0, 3) == 0) begin
        ena = 1'b0;
        ui_in = 8'($urandom_range(0, 15));
      end else begin
        ena = 1'b1;
        ui_in = 8'($urandom_range(0, 3));
      end
      tick();
      ena = 1'b1;
      ui_in = 8'h00;
      check_state("gap", a, b, k);
    end
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input bit gapped);
    do_start();
    for (int k = 0; k < W; k++) begin
      if (gapped) gaps(a, b, k, $urandom_range(1, 3), 1'b0);
      if (gapped && k == 4) gaps(a, b, k, 2, 1'b1);
      feed(a, b, k);
    end
  endtask
  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b1;
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    tick();
    rst_n = 1'b1;
    uio_in = 8'($urandom);
    tick();
    chk("idle_uo", uo_out, 8'h00);
    chk("idle_uio", uio_out, 8'h00);
    ui_in = 8'h07;
    tick();
    ui_in = 8'h00;
    chk("idle_valid_uo", uo_out, 8'h00);
    op(8'h5A, 8'h33, 1'b0);
    chk("s2_result", uio_out, 8'h8D);
    chk("s2_flags", uo_out & 8'h8C, 8'h04);
    op(8'hFF, 8'h01, 1'b0);
    chk("s3_result", uio_out, 8'h00);
    chk("s3_ovf", uo_out & 8'h80, 8'h80);
    op(8'h5A, 8'h33, 1'b1);
    chk("s4_result", uio_out, 8'h8D);
    do_start();
    for (int k = 0; k < 3; k++) feed(8'h5A, 8'h33, k);
    ui_in = 8'h0F;
    tick();
    ui_in = 8'h00;
    check_state("restart", 0, 0, 0);
    for (int k = 0; k < W; k++) feed(8'h0F, 8'h01, k);
    chk("s5_result", uio_out, 8'h10);
    chk("s5_ovf", uo_out & 8'h80, 8'h00);
    do_start();
    for (int k = 0; k < 5; k++) feed(8'hC3, 8'h96, k);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_uo", uo_out, 8'h00);
    chk("async_rst_uio", uio_out, 8'h00);
    tick();
    rst_n = 1'b1;
    ui_in = 8'h07;
    tick();
    ui_in = 8'h00;
    chk("post_rst_uo", uo_out, 8'h00);
    chk("post_rst_uio", uio_out, 8'h00);
    op(8'hC3, 8'h96, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ui_in = 8'($urandom_range(0, 7));
      tick();
      ui_in = 8'h00;
      check_state("done_hold", 8'hC3, 8'h96, W);
    end
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op(ra, rb, 1'(i % 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
